// File: rtl/controlador_sequenciador.sv
// Control/sequencer for an accumulator machine: a 6-state one-hot ring counter
// clocked on the falling edge, and a combinational control word decoded from T-state and opcode.
module controlador_sequenciador #(
    parameter logic [3:0] OP_LDA = 4'b0000,
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_SUB = 4'b0010,
    parameter logic [3:0] OP_OUT = 4'b1110,
    parameter logic [3:0] OP_HLT = 4'b1111
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] opcode,
    output logic       Cp,
    output logic       Ep,
    output logic       Lm_barra,
    output logic       CE_barra,
    output logic       Li_barra,
    output logic       Ei_barra,
    output logic       La_barra,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       Lb_barra,
    output logic       Lo_barra,
    output logic       HLT,
    output logic [5:0] T
);

    typedef enum logic [5:0] {
        S_T1 = 6'b000001,
        S_T2 = 6'b000010,
        S_T3 = 6'b000100,
        S_T4 = 6'b001000,
        S_T5 = 6'b010000,
        S_T6 = 6'b100000
    } t_state_e;

    t_state_e r_state;
    t_state_e w_next;
    logic     r_hlt;
    logic     w_hlt_next;

    // Falling-edge update keeps the control word settled for every rising edge.
    always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state <= S_T1;
            r_hlt   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_hlt   <= w_hlt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_hlt_next = r_hlt;
        if (!r_hlt) begin
            case (r_state)
                S_T1: w_next = S_T2;
                S_T2: w_next = S_T3;
                S_T3: begin
                    w_next = S_T4;
                    if (opcode == OP_HLT) begin
                        w_hlt_next = 1'b1;
                    end
                end
                S_T4:    w_next = S_T5;
                S_T5:    w_next = S_T6;
                S_T6:    w_next = S_T1;
                default: w_next = S_T1;
            endcase
        end
    end

    logic w_t1, w_t2, w_t3, w_t4, w_t5, w_t6;
    logic w_lda, w_add, w_sub, w_out;
    logic w_mem_op, w_arith;

    // Execute states are masked once halted so a changing opcode cannot leak through.
    assign w_t1 = r_state[0];
    assign w_t2 = r_state[1];
    assign w_t3 = r_state[2];
    assign w_t4 = r_state[3] & ~r_hlt;
    assign w_t5 = r_state[4] & ~r_hlt;
    assign w_t6 = r_state[5] & ~r_hlt;

    assign w_lda    = (opcode == OP_LDA);
    assign w_add    = (opcode == OP_ADD);
    assign w_sub    = (opcode == OP_SUB);
    assign w_out    = (opcode == OP_OUT);
    assign w_mem_op = w_lda | w_add | w_sub;
    assign w_arith  = w_add | w_sub;

    assign Cp       = w_t2;
    assign Ep       = w_t1;
    assign Lm_barra = ~(w_t1 | (w_t4 & w_mem_op));
    assign CE_barra = ~(w_t3 | (w_t5 & w_mem_op));
    assign Li_barra = ~w_t3;
    assign Ei_barra = ~(w_t4 & w_mem_op);
    assign La_barra = ~((w_t5 & w_lda) | (w_t6 & w_arith));
    assign Ea       = w_t4 & w_out;
    assign Su       = (w_t5 | w_t6) & w_sub;
    assign Eu       = w_t6 & w_arith;
    assign Lb_barra = ~(w_t5 & w_arith);
    assign Lo_barra = ~(w_t4 & w_out);

    assign HLT = r_hlt;
    assign T   = r_state;

endmodule

// File: tb/tb_controlador_sequenciador.sv
// Randomized scoreboard bench for controlador_sequenciador: an instruction-level model
// queues the expected T/HLT/control word per clock and a monitor compares on rising edges.
module tb_controlador_sequenciador;

    localparam logic [3:0] LDA = 4'b0000;
    localparam logic [3:0] ADD = 4'b0001;
    localparam logic [3:0] SUB = 4'b0010;
    localparam logic [3:0] OUT = 4'b1110;
    localparam logic [3:0] HLT_OP = 4'b1111;

    logic       CLK = 1'b0;
    logic       CLR;
    logic [3:0] opcode;
    logic       Cp, Ep, Lm_barra, CE_barra, Li_barra, Ei_barra;
    logic       La_barra, Ea, Su, Eu, Lb_barra, Lo_barra, HLT;
    logic [5:0] T;

    controlador_sequenciador dut (
        .CLK(CLK), .CLR(CLR), .opcode(opcode),
        .Cp(Cp), .Ep(Ep), .Lm_barra(Lm_barra), .CE_barra(CE_barra),
        .Li_barra(Li_barra), .Ei_barra(Ei_barra), .La_barra(La_barra), .Ea(Ea),
        .Su(Su), .Eu(Eu), .Lb_barra(Lb_barra), .Lo_barra(Lo_barra),
        .HLT(HLT), .T(T)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n;
    } ctl_t;

    typedef struct packed {
        logic [5:0] t;
        logic       h;
        ctl_t       w;
    } obs_t;

    obs_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    int         step;
    bit         halted;
    int         halt_cnt;
    int         hold;
    logic [3:0] op_cur;

    obs_t dut_obs;
    assign dut_obs = {T, HLT, Cp, Ep, Lm_barra, CE_barra, Li_barra, Ei_barra,
                      La_barra, Ea, Su, Eu, Lb_barra, Lo_barra};

    function automatic ctl_t idle_word();
        ctl_t c;
        c.cp = 0; c.ep = 0; c.lm_n = 1; c.ce_n = 1; c.li_n = 1; c.ei_n = 1;
        c.la_n = 1; c.ea = 0; c.su = 0; c.eu = 0; c.lb_n = 1; c.lo_n = 1;
        return c;
    endfunction

    // Micro-program table: what each instruction asserts in each T-state.
    function automatic ctl_t model_word(int s, logic [3:0] op, bit h);
        ctl_t c;
        bit   mem, arith;
        c     = idle_word();
        mem   = (op == LDA) || (op == ADD) || (op == SUB);
        arith = (op == ADD) || (op == SUB);
        if (s == 1) begin c.ep = 1; c.lm_n = 0; end
        if (s == 2) c.cp = 1;
        if (s == 3) begin c.ce_n = 0; c.li_n = 0; end
        if (!h && s == 4 && mem) begin c.lm_n = 0; c.ei_n = 0; end
        if (!h && s == 4 && op == OUT) begin c.ea = 1; c.lo_n = 0; end
        if (!h && s == 5 && op == LDA) begin c.ce_n = 0; c.la_n = 0; end
        if (!h && s == 5 && arith) begin c.ce_n = 0; c.lb_n = 0; c.su = (op == SUB); end
        if (!h && s == 6 && arith) begin c.la_n = 0; c.eu = 1; c.su = (op == SUB); end
        return c;
    endfunction

    function automatic obs_t model_obs();
        obs_t e;
        e.t = 6'd1 << (step - 1);
        e.h = halted;
        e.w = model_word(step, op_cur, halted);
        return e;
    endfunction

    task automatic check(string name, obs_t got, obs_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got T=%b HLT=%b word=%b, expected T=%b HLT=%b word=%b",
                     name, $time, got.t, got.h, got.w, exp.t, exp.h, exp.w);
        end
    endtask

    function automatic logic [3:0] pick_opcode();
        int r;
        r = $urandom_range(0, 99);
        if (r < 20) return LDA;
        if (r < 40) return ADD;
        if (r < 60) return SUB;
        if (r < 75) return OUT;
        if (r < 83) return HLT_OP;
        return 4'($urandom_range(3, 13));
    endfunction

    always @(posedge CLK) begin : monitor
        obs_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("cycle", dut_obs, e);
        end
    end

    initial begin
        CLR      = 1'b0;
        opcode   = 4'b0000;
        op_cur   = 4'b0000;
        step     = 1;
        halted   = 0;
        halt_cnt = 0;
        hold     = 2;
        #2 CLR = 1'b1;
        #2 check("reset", dut_obs, model_obs());

        for (int n = 0; n < 1500; n++) begin
            @(negedge CLK);
            if (!CLR) begin
                if (halted) begin
                    // frozen
                end else if (step == 3 && op_cur == HLT_OP) begin
                    step   = 4;
                    halted = 1;
                end else begin
                    step = (step == 6) ? 1 : step + 1;
                end
            end
            #1;
            if (CLR) begin
                if (hold == 0) CLR = 1'b0;
                else hold--;
            end else if ((halted && halt_cnt >= 12) ||
                         (step == 5 && op_cur == ADD && $urandom_range(0, 2) == 0) ||
                         ($urandom_range(0, 49) == 0)) begin
                #1 CLR = 1'b1;
                step     = 1;
                halted   = 0;
                halt_cnt = 0;
                hold     = $urandom_range(0, 2);
                #1 check("async_clr", dut_obs, model_obs());
            end
            if (step == 1) begin
                op_cur = pick_opcode();
                opcode = op_cur;
            end
            if (halted) begin
                halt_cnt++;
                opcode = 4'($urandom);
            end
            q.push_back(model_obs());
        end

        for (int k = 0; k < 5 && q.size() != 0; k++) @(posedge CLK);
        #1;
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expected entries never observed, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
